// File: rtl/mem320_writer.sv
`default_nettype none
// ============================================================================
//  Module      : mem320_writer
//  Description : Streaming frame writer for the two-bank 320-column pixel
//                store. Accepts 8-bit pixels on a valid/ready handshake after
//                a start pulse, splits the global pixel address into bank
//                select and bank-local address, drives registered write
//                strobes and pulses frame_done after the final write.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem320_writer #(
    parameter int FRAME_W    = 320,
    parameter int FRAME_H    = 480,
    parameter int BANK_DEPTH = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        we0,
    output logic        we1,
    output logic [16:0] waddr,
    output logic [7:0]  wdata,
    output logic        line_end,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [8:0]  c_last_col   = 9'(FRAME_W - 1);
    localparam logic [8:0]  c_last_row   = 9'(FRAME_H - 1);
    localparam logic [17:0] c_bank_depth = 18'(BANK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_LAST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [17:0] r_gaddr;
    logic [8:0]  r_col;
    logic [8:0]  r_row;

    logic        r_we0;
    logic        r_we1;
    logic [16:0] r_waddr;
    logic [7:0]  r_wdata;
    logic        r_line_end;
    logic        r_frame_done;

    logic        w_accept;
    logic        w_col_wrap;
    logic        w_last_pix;
    logic        w_bank1;
    logic [16:0] w_local;

    // Accept is qualified by the state directly so the handshake does not
    // loop back through the decoded pix_ready output.
    assign w_accept   = pix_valid && (r_state == S_WRITE);
    assign w_col_wrap = (r_col == c_last_col);
    // Final pixel of the frame is the last column of the last line.
    assign w_last_pix = w_col_wrap && (r_row == c_last_row);
    assign w_bank1    = (r_gaddr >= c_bank_depth);
    // Bank-local offset: subtract at full 18-bit width, keep the low 17 bits.
    assign w_local    = w_bank1 ? 17'(r_gaddr - c_bank_depth) : r_gaddr[16:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the two state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        pix_ready    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (w_accept && w_last_pix) begin
                    w_state_next = S_LAST;
                end
            end
            S_LAST: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Global address and column/row counters; cleared on an honoured start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gaddr <= 18'd0;
            r_col   <= 9'd0;
            r_row   <= 9'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_gaddr <= 18'd0;
            r_col   <= 9'd0;
            r_row   <= 9'd0;
        end else if (w_accept) begin
            r_gaddr <= r_gaddr + 18'd1;
            if (w_col_wrap) begin
                r_col <= 9'd0;
                r_row <= r_row + 9'd1;
            end else begin
                r_col <= r_col + 9'd1;
            end
        end
    end

    // Registered write port: strobes live for exactly the cycle after an
    // accept; address and data hold their last value between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we0        <= 1'b0;
            r_we1        <= 1'b0;
            r_waddr      <= 17'd0;
            r_wdata      <= 8'd0;
            r_line_end   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_we0        <= w_accept && !w_bank1;
            r_we1        <= w_accept && w_bank1;
            r_line_end   <= w_accept && w_col_wrap;
            r_frame_done <= (r_state == S_LAST);
            if (w_accept) begin
                r_waddr <= w_local;
                r_wdata <= pix_data;
            end
        end
    end

    assign we0        = r_we0;
    assign we1        = r_we1;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign line_end   = r_line_end;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_mem320_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem320_writer
//  Description : Directed self-checking bench for mem320_writer, run on a
//                reduced 16x10 frame (two banks of 80) so whole frames,
//                the bank switch and line wraps all fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem320_writer;

    localparam int FW   = 16;
    localparam int FH   = 10;
    localparam int BD   = 80;
    localparam int NPIX = FW * FH;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        we0;
    logic        we1;
    logic [16:0] waddr;
    logic [7:0]  wdata;
    logic        line_end;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem320_writer #(
        .FRAME_W    (FW),
        .FRAME_H    (FH),
        .BANK_DEPTH (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .we0        (we0),
        .we1        (we1),
        .waddr      (waddr),
        .wdata      (wdata),
        .line_end   (line_end),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
        repeat (3) step();
        total++;
        if ({pix_ready, we0, we1, waddr, wdata, line_end, busy, frame_done} !== 31'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {pix_ready, we0, we1, waddr, wdata, line_end, busy, frame_done});
        end
        rst = 1'b0;
        step();
        total++;
        if ({pix_ready, busy} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got ready=%b busy=%b want 0 0", pix_ready, busy);
        end
    endtask

    task automatic test_full_frame();
        logic        e0;
        logic [16:0] ea;
        logic        el;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if ({pix_ready, busy} !== 2'b11) begin
            bad++;
            $display("FAIL full_start_ready: got ready=%b busy=%b want 1 1", pix_ready, busy);
        end
        for (int g = 0; g < NPIX; g++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(g);
            step();
            e0 = (g < BD);
            ea = (g < BD) ? 17'(g) : 17'(g - BD);
            el = ((g % FW) == FW - 1);
            total++;
            if ({we0, we1, waddr, wdata, line_end, frame_done} !== {e0, !e0, ea, 8'(g), el, 1'b0}) begin
                bad++;
                $display("FAIL full_strobe[%0d]: got we0=%b we1=%b waddr=%0d wdata=%0d le=%b fd=%b want we0=%b we1=%b waddr=%0d wdata=%0d le=%b fd=0",
                         g, we0, we1, waddr, wdata, line_end, frame_done, e0, !e0, ea, 8'(g), el);
            end
        end
        pix_valid = 1'b0;
        total++;
        if ({pix_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL full_last_state: got ready=%b busy=%b want 0 1", pix_ready, busy);
        end
        step();
        total++;
        if ({frame_done, we0, we1, busy} !== 4'b1001) begin
            bad++;
            $display("FAIL full_done: got fd=%b we0=%b we1=%b busy=%b want 1 0 0 1",
                     frame_done, we0, we1, busy);
        end
        step();
        total++;
        if ({frame_done, busy, pix_ready} !== 3'b000) begin
            bad++;
            $display("FAIL full_idle: got fd=%b busy=%b ready=%b want 0 0 0",
                     frame_done, busy, pix_ready);
        end
    endtask

    task automatic test_gaps();
        int          k = 0;
        int          cyc = 0;
        int          nstrobe = 0;
        int          nle = 0;
        logic        v;
        logic        e0;
        logic [16:0] ea;
        start = 1'b1;
        step();
        start = 1'b0;
        while (k < NPIX && cyc < 4 * NPIX) begin
            v = (((cyc * 7) % 10) >= 3);
            pix_valid = v;
            pix_data  = 8'(k * 3 + 1);
            step();
            cyc++;
            nstrobe += int'(we0) + int'(we1);
            nle     += int'(line_end);
            total++;
            if (v) begin
                e0 = (k < BD);
                ea = (k < BD) ? 17'(k) : 17'(k - BD);
                if ({we0, we1, waddr, wdata} !== {e0, !e0, ea, 8'(k * 3 + 1)}) begin
                    bad++;
                    $display("FAIL gap_strobe[%0d]: got we0=%b we1=%b waddr=%0d wdata=%0d want we0=%b we1=%b waddr=%0d wdata=%0d",
                             k, we0, we1, waddr, wdata, e0, !e0, ea, 8'(k * 3 + 1));
                end
                k++;
            end else if ({we0, we1, line_end} !== 3'b000) begin
                bad++;
                $display("FAIL gap_idle[%0d]: got we0=%b we1=%b le=%b want 0 0 0",
                         cyc, we0, we1, line_end);
            end
        end
        pix_valid = 1'b0;
        total++;
        if (k != NPIX) begin
            bad++;
            $display("FAIL gap_budget: got %0d pixels want %0d", k, NPIX);
        end
        step();
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL gap_done: got fd=%b want 1", frame_done);
        end
        total++;
        if (nstrobe != NPIX || nle != FH) begin
            bad++;
            $display("FAIL gap_counts: got strobes=%0d line_ends=%0d want %0d %0d",
                     nstrobe, nle, NPIX, FH);
        end
        step();
    endtask

    task automatic test_ignore_start();
        pix_valid = 1'b1;
        pix_data  = 8'hAA;
        start     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({pix_ready, busy, we0, we1, line_end} !== 5'b00000) begin
                bad++;
                $display("FAIL idle_ignore[%0d]: got ready=%b busy=%b we0=%b we1=%b le=%b want all 0",
                         i, pix_ready, busy, we0, we1, line_end);
            end
        end
        pix_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int g = 0; g < NPIX; g++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(g);
            start     = (g == 5);
            step();
            start = 1'b0;
            if (g <= 10) begin
                total++;
                if ({we0, waddr} !== {1'b1, 17'(g)}) begin
                    bad++;
                    $display("FAIL write_start_ignored[%0d]: got we0=%b waddr=%0d want 1 %0d",
                             g, we0, waddr, g);
                end
            end
        end
        pix_valid = 1'b0;
        start = 1'b1;
        step();
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL ignore_done: got fd=%b want 1", frame_done);
        end
        step();
        start = 1'b0;
        total++;
        if ({busy, pix_ready} !== 2'b00) begin
            bad++;
            $display("FAIL done_start_ignored: got busy=%b ready=%b want 0 0", busy, pix_ready);
        end
        step();
        total++;
        if ({busy, pix_ready} !== 2'b00) begin
            bad++;
            $display("FAIL done_stays_idle: got busy=%b ready=%b want 0 0", busy, pix_ready);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int g = 0; g < 100; g++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(g + 1);
            step();
        end
        rst = 1'b1;
        #1;
        total++;
        if ({pix_ready, we0, we1, waddr, wdata, line_end, busy, frame_done} !== 31'd0) begin
            bad++;
            $display("FAIL reset_async: got %h want 0",
                     {pix_ready, we0, we1, waddr, wdata, line_end, busy, frame_done});
        end
        step();
        rst = 1'b0;
        pix_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({frame_done, busy} !== 2'b00) begin
                bad++;
                $display("FAIL reset_no_done[%0d]: got fd=%b busy=%b want 0 0", i, frame_done, busy);
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 8'h5A;
        step();
        total++;
        if ({we0, we1, waddr, wdata} !== {1'b1, 1'b0, 17'd0, 8'h5A}) begin
            bad++;
            $display("FAIL reset_restart: got we0=%b we1=%b waddr=%0d wdata=%h want 1 0 0 5a",
                     we0, we1, waddr, wdata);
        end
        for (int g = 1; g < NPIX; g++) begin
            step();
        end
        pix_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic        e0;
        logic [16:0] ea;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int g = 0; g < NPIX; g++) begin
                pix_valid = 1'b1;
                pix_data  = 8'(g + 7 * f);
                step();
                e0 = (g < BD);
                ea = (g < BD) ? 17'(g) : 17'(g - BD);
                total++;
                if ({we0, we1, waddr, wdata} !== {e0, !e0, ea, 8'(g + 7 * f)}) begin
                    bad++;
                    $display("FAIL b2b_strobe[%0d][%0d]: got we0=%b we1=%b waddr=%0d wdata=%0d want we0=%b we1=%b waddr=%0d wdata=%0d",
                             f, g, we0, we1, waddr, wdata, e0, !e0, ea, 8'(g + 7 * f));
                end
            end
            pix_valid = 1'b0;
            step();
            total++;
            if (frame_done !== 1'b1) begin
                bad++;
                $display("FAIL b2b_done[%0d]: got fd=%b want 1", f, frame_done);
            end
            step();
            total++;
            if ({frame_done, busy} !== 2'b00) begin
                bad++;
                $display("FAIL b2b_idle[%0d]: got fd=%b busy=%b want 0 0", f, frame_done, busy);
            end
            if (f == 0) begin
                start = 1'b1;
                step();
                start = 1'b0;
                total++;
                if (pix_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_restart: got ready=%b want 1", pix_ready);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
        test_reset();
        test_full_frame();
        test_gaps();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
